pe_dispatch: RTL and testbench

PE_DISPATCH -- requirements
Module: pe_dispatch

---
 rtl/pe_dispatch_pkg.sv | 22 ++
 rtl/pe_dispatch_result_fifo.sv | 55 +++++
 rtl/pe_dispatch.sv | 167 ++++++++++++++++
 tb/tb_pe_dispatch.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_dispatch_pkg.sv
// Shared definitions for the PE dispatcher: FSM encoding, PE control bit
// positions and result-buffer sizing.
package pe_dispatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int CTL_FIRST = 0;
    localparam int CTL_LAST  = 1;

    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

    // One credit per result slot; a dot product claims its slot when its last beat is read.
    localparam int CREDIT_W = FIFO_CNT_W;
    localparam logic [CREDIT_W-1:0] CREDIT_INIT = CREDIT_W'(FIFO_DEPTH);

endpackage

// File: rtl/pe_dispatch_result_fifo.sv
// Small result buffer between the PE and the output stream. The caller
// guarantees push is only raised when a slot is free (or freed by pop).
module pe_result_fifo
    import pe_dispatch_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    logic [W-1:0]          mem [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr;
    logic [FIFO_PTR_W-1:0] rd_ptr;
    logic [FIFO_CNT_W-1:0] count;
    logic                  do_pop;

    assign do_pop = pop && !empty;
    assign full   = (count == FIFO_CNT_W'(FIFO_DEPTH));
    assign empty  = (count == '0);
    assign dout   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + FIFO_PTR_W'(1);
            end
            unique case ({push, do_pop})
                2'b10:   count <= count + FIFO_CNT_W'(1);
                2'b01:   count <= count - FIFO_CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pe_dispatch.sv
// Streams neuron/weight beats from the operand buffers into a dot-product PE
// and forwards PE results through a credit-guarded result FIFO.
module pe_dispatch
    import pe_dispatch_pkg::*;
#(
    parameter int DW = 512,
    parameter int AW = 10,
    parameter int LW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] n_base,
    input  logic [AW-1:0] w_base,
    input  logic [LW-1:0] vec_len_m1,
    input  logic [LW-1:0] num_dots_m1,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] n_addr,
    output logic [AW-1:0] w_addr,
    input  logic [DW-1:0] n_rdata,
    input  logic [DW-1:0] w_rdata,
    output logic [DW-1:0] pe_neuron,
    output logic [DW-1:0] pe_weight,
    output logic [1:0]    pe_ctl,
    output logic          pe_vld_i,
    input  logic [31:0]   pe_result,
    input  logic          pe_vld_o,
    output logic [31:0]   out_data,
    output logic          out_vld,
    input  logic          out_rdy
);

    state_t state;
    state_t state_nxt;

    logic [AW-1:0]       n_base_q;
    logic [LW-1:0]       vec_len_q;
    logic [LW-1:0]       num_dots_q;
    logic [LW-1:0]       beat;
    logic [LW-1:0]       dot;
    logic [AW-1:0]       w_ptr;
    logic [CREDIT_W-1:0] credit;

    logic beat_first;
    logic beat_last;
    logic issue;
    logic issue_last;
    logic drain_done;
    logic fifo_push;
    logic fifo_pop;
    logic fifo_full;
    logic fifo_empty;

    assign beat_first = (beat == '0);
    assign beat_last  = (beat == vec_len_q);
    // Only the last beat needs a credit: it is the one that eventually yields a result.
    assign issue      = (state == ST_RUN) && !(beat_last && (credit == '0));
    assign issue_last = issue && beat_last;
    assign drain_done = (state == ST_DRAIN) && fifo_empty
                        && (credit == CREDIT_INIT) && !pe_vld_i;

    assign n_addr    = n_base_q + AW'(beat);
    assign w_addr    = w_ptr;
    assign pe_neuron = n_rdata;
    assign pe_weight = w_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        rd_en     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy  = 1'b1;
                rd_en = issue;
                if (issue_last && (dot == num_dots_q)) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (drain_done) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_base_q   <= '0;
            vec_len_q  <= '0;
            num_dots_q <= '0;
            beat       <= '0;
            dot        <= '0;
            w_ptr      <= '0;
        end else if ((state == ST_IDLE) && start) begin
            n_base_q   <= n_base;
            vec_len_q  <= vec_len_m1;
            num_dots_q <= num_dots_m1;
            beat       <= '0;
            dot        <= '0;
            w_ptr      <= w_base;
        end else if (issue) begin
            // Weight rows are packed back to back, so one running pointer covers k*(len)+i.
            w_ptr <= w_ptr + AW'(1);
            if (beat_last) begin
                beat <= '0;
                dot  <= dot + LW'(1);
            end else begin
                beat <= beat + LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credit   <= CREDIT_INIT;
            pe_vld_i <= 1'b0;
            pe_ctl   <= '0;
        end else begin
            unique case ({issue_last, fifo_pop})
                2'b10:   credit <= credit - CREDIT_W'(1);
                2'b01:   credit <= credit + CREDIT_W'(1);
                default: credit <= credit;
            endcase
            pe_vld_i          <= issue;
            pe_ctl[CTL_FIRST] <= issue && beat_first;
            pe_ctl[CTL_LAST]  <= issue && beat_last;
        end
    end

    assign out_vld   = !fifo_empty;
    assign fifo_pop  = out_vld && out_rdy;
    assign fifo_push = pe_vld_o && (!fifo_full || fifo_pop);

    pe_result_fifo #(
        .W (32)
    ) u_result_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (pe_result),
        .pop   (fifo_pop),
        .dout  (out_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_pe_dispatch.sv
// Directed bench for pe_dispatch with buffer and PE models and a result scoreboard.
module tb_pe_dispatch;

    localparam int DW = 512;
    localparam int AW = 10;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] n_base;
    logic [AW-1:0] w_base;
    logic [LW-1:0] vec_len_m1;
    logic [LW-1:0] num_dots_m1;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] n_addr;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] n_rdata;
    logic [DW-1:0] w_rdata;
    logic [DW-1:0] pe_neuron;
    logic [DW-1:0] pe_weight;
    logic [1:0]    pe_ctl;
    logic          pe_vld_i;
    logic [31:0]   pe_result;
    logic          pe_vld_o;
    logic [31:0]   out_data;
    logic          out_vld;
    logic          out_rdy;

    always #5 clk = ~clk;

    pe_dispatch #(
        .DW (DW),
        .AW (AW),
        .LW (LW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .n_base      (n_base),
        .w_base      (w_base),
        .vec_len_m1  (vec_len_m1),
        .num_dots_m1 (num_dots_m1),
        .busy        (busy),
        .done        (done),
        .rd_en       (rd_en),
        .n_addr      (n_addr),
        .w_addr      (w_addr),
        .n_rdata     (n_rdata),
        .w_rdata     (w_rdata),
        .pe_neuron   (pe_neuron),
        .pe_weight   (pe_weight),
        .pe_ctl      (pe_ctl),
        .pe_vld_i    (pe_vld_i),
        .pe_result   (pe_result),
        .pe_vld_o    (pe_vld_o),
        .out_data    (out_data),
        .out_vld     (out_vld),
        .out_rdy     (out_rdy)
    );

    function automatic logic [31:0] nval(input int a);
        return 32'(a * 3 + 1);
    endfunction

    function automatic logic [31:0] wval(input int a);
        return 32'(a * 7 + 2);
    endfunction

    // Operand buffers: read data one cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) begin
            n_rdata <= {(DW/32){nval(int'(n_addr))}};
            w_rdata <= {(DW/32){wval(int'(w_addr))}};
        end
    end

    // PE: accumulates lane-0 16-bit products, result one cycle after the last beat.
    logic [31:0] acc;
    always @(posedge clk) begin : pe_model
        logic [31:0] nxt;
        if (!rst_n) begin
            pe_vld_o  <= 1'b0;
            pe_result <= '0;
            acc       <= '0;
        end else begin
            pe_vld_o <= 1'b0;
            if (pe_vld_i) begin
                nxt = (pe_ctl[0] ? 32'd0 : acc)
                      + 32'(pe_neuron[15:0]) * 32'(pe_weight[15:0]);
                acc <= nxt;
                if (pe_ctl[1]) begin
                    pe_vld_o  <= 1'b1;
                    pe_result <= nxt;
                end
            end
        end
    end

    int passed = 0;
    int total  = 0;
    int fails  = 0;
    int cyc    = 0;
    int start_cyc = 0;
    int done_cnt  = 0;
    int pop_cnt   = 0;
    int first_rd  = -1;
    int first_out = -1;
    logic [31:0] exp_q [$];
    int          tr_n  [$];
    int          tr_w  [$];
    logic [1:0]  tr_ctl[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sample();
        logic [31:0] e;
        if (rd_en) begin
            tr_n.push_back(int'(n_addr));
            tr_w.push_back(int'(w_addr));
            if (first_rd < 0) first_rd = cyc;
        end
        if (pe_vld_i) tr_ctl.push_back(pe_ctl);
        if (out_vld && first_out < 0) first_out = cyc;
        if (out_vld && out_rdy) begin
            pop_cnt++;
            total++;
            assert (exp_q.size() > 0) begin
                passed++;
                e = exp_q.pop_front();
                check("result_data", 64'(out_data), 64'(e));
            end else begin
                fails++;
                $error("FAIL result_extra: observed %0d expected no result", out_data);
            end
        end
        if (done) done_cnt++;
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [31:0] exp_dot(input int nb, input int wb, input int vl, input int k);
        logic [31:0] s;
        logic [31:0] a;
        logic [31:0] b;
        s = '0;
        for (int i = 0; i <= vl; i++) begin
            a = nval((nb + i) % 1024);
            b = wval((wb + k * (vl + 1) + i) % 1024);
            s = s + 32'(a[15:0]) * 32'(b[15:0]);
        end
        return s;
    endfunction

    task automatic start_job(input int nb, input int wb, input int vl, input int nd);
        tr_n.delete();
        tr_w.delete();
        tr_ctl.delete();
        first_rd  = -1;
        first_out = -1;
        for (int k = 0; k <= nd; k++) exp_q.push_back(exp_dot(nb, wb, vl, k));
        n_base      = AW'(nb);
        w_base      = AW'(wb);
        vec_len_m1  = LW'(vl);
        num_dots_m1 = LW'(nd);
        start       = 1'b1;
        start_cyc   = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int d0;
        d0 = done_cnt;
        for (int n = 0; n < limit && done_cnt == d0; n++) step();
        steps(3);
        check({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
        check({tag, "_idle"}, 64'(busy), 64'd0);
        check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    function automatic int qi(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int d0;
        rst_n = 1'b0; start = 1'b0; out_rdy = 1'b1;
        n_base = '0; w_base = '0; vec_len_m1 = '0; num_dots_m1 = '0;
        steps(3);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_rd_en", 64'(rd_en), 0);
        check("rst_pe_vld_i", 64'(pe_vld_i), 0);
        check("rst_pe_ctl", 64'(pe_ctl), 0);
        check("rst_out_vld", 64'(out_vld), 0);
        rst_n = 1'b1;
        step();

        // Single four-beat dot product.
        p0 = pop_cnt;
        start_job(0, 16, 3, 0);
        wait_done("t1", 60);
        check("t1_nreads", 64'(tr_n.size()), 4);
        for (int i = 0; i < 4; i++) begin
            check("t1_n_addr", 64'(qi(tr_n, i)), 64'(i));
            check("t1_w_addr", 64'(qi(tr_w, i)), 64'(16 + i));
        end
        check("t1_ctl0", 64'(tr_ctl.size() > 0 ? tr_ctl[0] : 2'bxx), 64'd1);
        check("t1_ctl1", 64'(tr_ctl.size() > 1 ? tr_ctl[1] : 2'bxx), 64'd0);
        check("t1_ctl2", 64'(tr_ctl.size() > 2 ? tr_ctl[2] : 2'bxx), 64'd0);
        check("t1_ctl3", 64'(tr_ctl.size() > 3 ? tr_ctl[3] : 2'bxx), 64'd2);
        check("t1_first_rd", 64'(first_rd - start_cyc), 1);
        check("t1_results", 64'(pop_cnt - p0), 1);

        // Single-beat dots; a start pulse mid-job must be ignored.
        p0 = pop_cnt;
        start_job(0, 16, 0, 2);
        n_base = 10'd100; w_base = 10'd200; vec_len_m1 = 8'd5; num_dots_m1 = 8'd7;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("t2", 60);
        check("t2_nreads", 64'(tr_w.size()), 3);
        for (int i = 0; i < 3; i++) begin
            check("t2_w_addr", 64'(qi(tr_w, i)), 64'(16 + i));
            check("t2_ctl", 64'(tr_ctl.size() > i ? tr_ctl[i] : 2'bxx), 64'd3);
        end
        check("t2_first_rd", 64'(first_rd - start_cyc), 1);
        check("t2_first_out", 64'(first_out - start_cyc), 4);
        check("t2_results", 64'(pop_cnt - p0), 3);
        steps(10);
        check("t2_no_restart", 64'(tr_w.size()), 3);

        // Back-pressure: two results buffered, third last beat withheld.
        p0 = pop_cnt;
        out_rdy = 1'b0;
        start_job(0, 16, 1, 4);
        steps(30);
        check("t3_out_vld", 64'(out_vld), 1);
        check("t3_busy", 64'(busy), 1);
        check("t3_rd_stalled", 64'(rd_en), 0);
        check("t3_reads_held", 64'(tr_n.size()), 5);
        check("t3_no_pop", 64'(pop_cnt - p0), 0);
        out_rdy = 1'b1;
        wait_done("t3", 200);
        check("t3_results", 64'(pop_cnt - p0), 5);
        check("t3_reads", 64'(tr_n.size()), 10);

        // Address wrap modulo 2^AW.
        start_job(1021, 1022, 3, 0);
        wait_done("t4", 60);
        check("t4_w0", 64'(qi(tr_w, 0)), 1022);
        check("t4_w1", 64'(qi(tr_w, 1)), 1023);
        check("t4_w2", 64'(qi(tr_w, 2)), 0);
        check("t4_w3", 64'(qi(tr_w, 3)), 1);
        check("t4_n3", 64'(qi(tr_n, 3)), 0);

        // Reset in the middle of RUN aborts without done.
        d0 = done_cnt;
        start_job(0, 16, 3, 3);
        steps(2);
        rst_n = 1'b0;
        step();
        exp_q.delete();
        check("t5_busy", 64'(busy), 0);
        check("t5_done", 64'(done), 0);
        check("t5_rd_en", 64'(rd_en), 0);
        check("t5_pe_vld_i", 64'(pe_vld_i), 0);
        check("t5_pe_ctl", 64'(pe_ctl), 0);
        check("t5_out_vld", 64'(out_vld), 0);
        rst_n = 1'b1;
        steps(10);
        check("t5_no_done", 64'(done_cnt - d0), 0);
        check("t5_quiet_out", 64'(out_vld), 0);
        check("t5_quiet_busy", 64'(busy), 0);

        // Fresh job after reset.
        p0 = pop_cnt;
        start_job(5, 40, 1, 1);
        wait_done("t6", 60);
        check("t6_results", 64'(pop_cnt - p0), 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
